// File: rtl/result_drain.sv
// Result drain: snapshots the four controller result lanes into a
// two-bank ping-pong buffer and streams them out one word per beat.
module result_drain #(
  parameter int DATA_W  = 32,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cap_valid,
  input  logic [DATA_W-1:0]  mem_data1,
  input  logic [DATA_W-1:0]  mem_data2,
  input  logic [DATA_W-1:0]  mem_data3,
  input  logic [DATA_W-1:0]  mem_data4,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic [1:0]         bank_count,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               overflow
);

  logic [DATA_W-1:0] bank_q [2][4];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] beat;

  logic xfer;
  logic last_xfer;
  logic bank_free;
  logic cap_take;
  logic cap_drop;

  assign out_valid = (bank_count != 2'd0);
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & (beat == 2'd3);

  // A full buffer still frees a bank if its last beat leaves this edge
  assign bank_free = (bank_count != 2'd2) | last_xfer;
  assign cap_take  = cap_valid & bank_free;
  assign cap_drop  = cap_valid & ~bank_free;

  assign out_idx  = beat;
  assign out_last = out_valid & (beat == 2'd3);
  assign out_data = out_valid ? bank_q[rd_ptr][beat] : '0;

  always_ff @(posedge clk) begin
    if (!reset && cap_take) begin
      bank_q[wr_ptr][0] <= mem_data1;
      bank_q[wr_ptr][1] <= mem_data2;
      bank_q[wr_ptr][2] <= mem_data3;
      bank_q[wr_ptr][3] <= mem_data4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      beat       <= 2'd0;
      bank_count <= 2'd0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (cap_take)
        wr_ptr <= ~wr_ptr;
      if (xfer)
        beat <= beat + 2'd1;
      if (last_xfer) begin
        rd_ptr    <= ~rd_ptr;
        frame_cnt <= frame_cnt + 1'b1;
      end
      case ({cap_take, last_xfer})
        2'b10:   bank_count <= bank_count + 2'd1;
        2'b01:   bank_count <= bank_count - 2'd1;
        default: bank_count <= bank_count;
      endcase
      if (cap_drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: scoreboard of expected beats checked on
// every valid cycle, a table-driven drop sequence, directed corners.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap_valid = 1'b0;
  logic [31:0] mem_data1 = '0;
  logic [31:0] mem_data2 = '0;
  logic [31:0] mem_data3 = '0;
  logic [31:0] mem_data4 = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [1:0]  bank_count;
  logic [7:0]  frame_cnt;
  logic        overflow;

  always #5 clk = ~clk;

  result_drain #(.DATA_W(32), .FRAME_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_valid  (cap_valid),
    .mem_data1  (mem_data1),
    .mem_data2  (mem_data2),
    .mem_data3  (mem_data3),
    .mem_data4  (mem_data4),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .bank_count (bank_count),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    logic        cap;
    logic [31:0] base;
    logic        rdy;
    logic        acc;
    logic [1:0]  bc;
    logic        vld;
    logic        ovf;
    logic [7:0]  fc;
  } vec_t;

  beat_t q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    xfer_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pending beat must be presented (and held) until it transfers
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("beat", 64'({out_data, out_idx, out_last}), 64'(q[0]));
        if (out_ready) begin
          void'(q.pop_front());
          xfer_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap_set(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input bit acc);
    cap_valid = 1'b1;
    mem_data1 = a;
    mem_data2 = b;
    mem_data3 = c;
    mem_data4 = d;
    if (acc) begin
      q.push_back('{d: a, idx: 2'd0, last: 1'b0});
      q.push_back('{d: b, idx: 2'd1, last: 1'b0});
      q.push_back('{d: c, idx: 2'd2, last: 1'b0});
      q.push_back('{d: d, idx: 2'd3, last: 1'b1});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cap_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    q.delete();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_bc", 64'(bank_count), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_fc", 64'(frame_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
  endtask

  vec_t tbl[13];
  int   x0;
  int   peak;
  bit   pat[7];

  initial begin
    tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 32'h20, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 32'h30, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd0};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd0};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1};
    tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Single frame
    do_reset();
    out_ready = 1'b1;
    cap_set(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b1);
    tick();
    cap_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_bc", 64'(bank_count), 64'd1);
    repeat (4) tick();
    chk("t1_fc", 64'(frame_cnt), 64'd1);
    chk("t1_bc_end", 64'(bank_count), 64'd0);
    chk("t1_q", 64'(q.size()), 64'd0);

    // Back-to-back captures, no bubble
    do_reset();
    out_ready = 1'b1;
    cap_set(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b1);
    tick();
    x0 = xfer_cnt;
    cap_set(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 1'b1);
    tick();
    cap_valid = 1'b0;
    peak = int'(bank_count);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (int'(bank_count) > peak) peak = int'(bank_count);
    end
    chk("t2_xfers", 64'(xfer_cnt - x0), 64'd8);
    chk("t2_peak", 64'(peak), 64'd2);
    chk("t2_fc", 64'(frame_cnt), 64'd2);
    chk("t2_bc", 64'(bank_count), 64'd0);

    // Table: fill both banks, drop third, then drain
    do_reset();
    for (int i = 0; i < 13; i++) begin
      out_ready = tbl[i].rdy;
      if (tbl[i].cap)
        cap_set(tbl[i].base, tbl[i].base + 1, tbl[i].base + 2,
                tbl[i].base + 3, tbl[i].acc);
      tick();
      cap_valid = 1'b0;
      chk($sformatf("tbl%0d_bc", i), 64'(bank_count), 64'(tbl[i].bc));
      chk($sformatf("tbl%0d_vld", i), 64'(out_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d_fc", i), 64'(frame_cnt), 64'(tbl[i].fc));
    end
    chk("tbl_q", 64'(q.size()), 64'd0);

    // Backpressure pattern
    do_reset();
    cap_set(32'hdead0000, 32'hbeef0001, 32'hcafe0002, 32'hf00d0003, 1'b1);
    tick();
    cap_valid = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b0;
    chk("t4_xfers", 64'(xfer_cnt - x0), 64'd4);
    chk("t4_bc", 64'(bank_count), 64'd0);
    chk("t4_fc", 64'(frame_cnt), 64'd1);
    chk("t4_q", 64'(q.size()), 64'd0);

    // Capture lands on the edge that frees a full buffer
    do_reset();
    cap_set(32'ha0, 32'ha1, 32'ha2, 32'ha3, 1'b1);
    tick();
    cap_set(32'hb0, 32'hb1, 32'hb2, 32'hb3, 1'b1);
    tick();
    cap_valid = 1'b0;
    chk("t5_full", 64'(bank_count), 64'd2);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t5_idx3", 64'(out_idx), 64'd3);
    cap_set(32'hc0, 32'hc1, 32'hc2, 32'hc3, 1'b1);
    tick();
    cap_valid = 1'b0;
    chk("t5_bc", 64'(bank_count), 64'd2);
    chk("t5_ovf", 64'(overflow), 64'd0);
    chk("t5_fc", 64'(frame_cnt), 64'd1);
    repeat (8) tick();
    chk("t5_bc_end", 64'(bank_count), 64'd0);
    chk("t5_fc_end", 64'(frame_cnt), 64'd3);
    chk("t5_ovf_end", 64'(overflow), 64'd0);
    chk("t5_q", 64'(q.size()), 64'd0);

    // Reset mid-drain
    do_reset();
    out_ready = 1'b1;
    cap_set(32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    tick();
    cap_valid = 1'b0;
    repeat (2) tick();
    chk("t6_idx2", 64'(out_idx), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_bc", 64'(bank_count), 64'd0);
    chk("t6_fc", 64'(frame_cnt), 64'd0);
    tick();
    chk("t6_idle", 64'(out_valid), 64'd0);
    cap_set(32'h55, 32'h66, 32'h77, 32'h88, 1'b1);
    tick();
    cap_valid = 1'b0;
    chk("t6_idx0", 64'(out_idx), 64'd0);
    repeat (4) tick();
    chk("t6_fc_end", 64'(frame_cnt), 64'd1);
    chk("t6_q", 64'(q.size()), 64'd0);

    // frame_cnt wrap with random data
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      cap_set($urandom, $urandom, $urandom, $urandom, 1'b1);
      tick();
      cap_valid = 1'b0;
      repeat (4) tick();
      if (f == 254) chk("wrap_255", 64'(frame_cnt), 64'd255);
    end
    chk("wrap_0", 64'(frame_cnt), 64'd0);
    chk("wrap_ovf", 64'(overflow), 64'd0);
    chk("wrap_q", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream of the systolic-array controller; consumes its four 32-bit result lanes mem_data1..mem_data4.
- Snapshots all four lanes on a capture pulse into a two-bank ping-pong buffer.
- Streams the snapshot out one word per beat over a valid/ready interface, for host readback or a result memory.
- Keeps a frame counter and a sticky overflow flag so dropped result sets are visible.

Parameters:
DATA_W, 32, width of each result lane and of out_data (IEEE-754 single for the current array)
FRAME_W, 8, width of the completed-frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cap_valid  in  1  one-cycle pulse: mem_data1..4 hold a finished result set this cycle
mem_data1  in  DATA_W  result lane 0 from controller
mem_data2  in  DATA_W  result lane 1
mem_data3  in  DATA_W  result lane 2
mem_data4  in  DATA_W  result lane 3
out_ready  in  1  consumer accepts a beat this cycle
out_valid  out  1  out_data/out_idx/out_last valid
out_data  out  DATA_W  current result word
out_idx  out  2  lane index of out_data (0..3 = mem_data1..4)
out_last  out  1  high on the idx-3 beat of a frame
bank_count  out  2  number of full banks (0, 1, 2)
frame_cnt  out  FRAME_W  frames fully drained since reset, wraps
overflow  out  1  sticky: a capture was dropped

Behaviour:
- Reset (synchronous, sampled on clk edge while reset=1):
  - bank_count=0, out_valid=0, out_data=0, out_idx=0, out_last=0, frame_cnt=0, overflow=0.
  - Write and read bank pointers reset to 0.
  - Reset mid-drain discards both banks; no further beats appear until a new capture.
- Capture:
  - On an edge with cap_valid=1 and a free bank, all four lanes are written into the write bank.
  - The write pointer toggles and bank_count increments.
  - A bank is free if bank_count<2, or if bank_count=2 and the final beat of the read bank transfers on the same edge. In that case the capture is accepted and bank_count stays 2.
- Drop:
  - cap_valid=1 with no free bank: data is discarded, banks are untouched, and overflow is set.
  - overflow holds until reset.
- Drain:
  - out_valid = (bank_count != 0).
  - out_data is the read bank's word selected by the beat index; out_idx is the beat index; out_last = out_valid & (idx==3).
  - A transfer happens when out_valid & out_ready; the beat index then increments.
  - On the idx-3 transfer: the beat index returns to 0, the read pointer toggles, bank_count decrements (unless a capture lands that same edge), and frame_cnt increments, wrapping from 2^FRAME_W-1 to 0.
- Latency and throughput:
  - A capture on edge N gives out_valid=1 from edge N onward, with the idx-0 word visible in the cycle after edge N.
  - With out_ready held high, a frame drains in 4 cycles.
  - Back-to-back banks drain with no bubble.
- Stability: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- No simultaneous read/write hazard: a capture only ever targets the bank not being read, or a bank that is freed that same edge.
- cap_valid pulses longer than one cycle are treated as repeated captures, each lands in a new bank or sets overflow.
- Data is stored bit-exact; no float interpretation.

Test Plan:
- Reset, then capture with mem_data1..4 = 3f800000, 40000000, 40400000, 40800000 and out_ready=1 -> beats with idx 0..3 carry those words in order; out_last only on 40800000; frame_cnt=1; bank_count returns to 0.
- Two captures on consecutive cycles (second set 40800000 x4), out_ready=1 -> 8 consecutive beats with no gap; bank_count peaks at 2; frame_cnt=2.
- out_ready=0 with three captures (values 1..3 per frame) -> bank_count=2; third capture dropped; overflow=1; later draining gives only frames 1 and 2; overflow stays 1.
- Backpressure: toggle out_ready 1,0,0,1,1,0,1 during a frame -> exactly 4 transfers; out_data stable during stalls; no word lost or repeated.
- bank_count=2; capture on the same edge as the idx-3 transfer of the read bank -> capture accepted, overflow stays 0, bank_count stays 2, new frame follows.
- Reset asserted after the idx-1 beat -> next cycle out_valid=0, bank_count=0, frame_cnt=0; a fresh capture then drains starting at idx 0.
